// File: rtl/lava_pkg.sv
// Shared types and field layout for the LED-panel frame buffer.
package lava_pkg;

  // Default panel geometry
  localparam int COLS_DEF = 64;
  localparam int ROWS_DEF = 32;

  // RGB444 pixel
  typedef logic [11:0] rgb444_t;

  localparam int R_MSB = 11;
  localparam int R_LSB = 8;
  localparam int G_MSB = 7;
  localparam int G_LSB = 4;
  localparam int B_MSB = 3;
  localparam int B_LSB = 0;

  // Display read address layout: {row pair, column}
  localparam int RA_ROW_MSB = 9;
  localparam int RA_ROW_LSB = 6;
  localparam int RA_COL_MSB = 5;
  localparam int RA_COL_LSB = 0;

  // Assemble a pixel from its three channels
  function automatic rgb444_t mk_rgb(input logic [3:0] r, input logic [3:0] g,
                                     input logic [3:0] b);
    rgb444_t p;
    p = 12'h000;
    p[R_MSB:R_LSB] = r;
    p[G_MSB:G_LSB] = g;
    p[B_MSB:B_LSB] = b;
    return p;
  endfunction

  // Assemble a display read address from row pair and column
  function automatic logic [9:0] ra_pack(input logic [3:0] row, input logic [5:0] col);
    logic [9:0] a;
    a = 10'h000;
    a[RA_ROW_MSB:RA_ROW_LSB] = row;
    a[RA_COL_MSB:RA_COL_LSB] = col;
    return a;
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port pixel RAM: one write port, one registered read port.
// Contents are never reset.
module fb_ram #(
  parameter int AW = 11,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_data_d;
  logic [DW-1:0] rd_data_q;

  // Combinational array lookup feeding the read register
  always_comb begin
    rd_data_d = mem[rd_addr];
  end

  // Write port and one-cycle registered read
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/frame_buf.sv
// Double-buffered LED-panel frame buffer. The writer fills the back bank,
// signals frame_done, and the banks swap at the next scan wrap (row 15 -> 0).
module frame_buf
  import lava_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         wr_valid,
  output logic                                         wr_ready,
  input  logic [$clog2(COLS)-1:0]                      wr_x,
  input  logic [$clog2(ROWS)-1:0]                      wr_y,
  input  logic [11:0]                                  wr_rgb,
  input  logic                                         frame_done,
  input  logic [$clog2(ROWS/2)-1:0]                    row_sel,
  input  logic [$clog2(ROWS/2)+$clog2(COLS)-1:0]       r_addr,
  output logic [11:0]                                  din_top,
  output logic [11:0]                                  din_btm,
  output logic                                         swap_pending,
  output logic                                         front_bank,
  output logic [7:0]                                   frame_cnt
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS/2);
  localparam int AW    = 1 + ROW_W + COL_W;

  logic             front_bank_q,   front_bank_d;
  logic             swap_pending_q, swap_pending_d;
  logic [7:0]       frame_cnt_q,    frame_cnt_d;
  logic [ROW_W-1:0] prev_row_sel_q, prev_row_sel_d;
  // Marks that the RAM read registers hold a real read since reset
  logic             rd_vld_q,       rd_vld_d;

  logic             wrap_s;
  logic             wr_fire_s;
  logic             wr_top_en_s;
  logic             wr_btm_en_s;
  logic [AW-1:0]    wr_addr_s;
  logic [AW-1:0]    rd_addr_s;
  rgb444_t          ram_top_s;
  rgb444_t          ram_btm_s;

  // Scan-wrap detect and RAM port decode (writes target the back bank)
  always_comb begin
    wrap_s      = (prev_row_sel_q == {ROW_W{1'b1}}) && (row_sel == {ROW_W{1'b0}});
    wr_fire_s   = wr_valid && !swap_pending_q;
    wr_top_en_s = wr_fire_s && !wr_y[ROW_W];
    wr_btm_en_s = wr_fire_s &&  wr_y[ROW_W];
    wr_addr_s   = {!front_bank_q, wr_y[ROW_W-1:0], wr_x};
    rd_addr_s   = {front_bank_q, r_addr[COL_W +: ROW_W], r_addr[COL_W-1:0]};
  end

  // Swap control: frame_done arms a swap, the next wrap performs it
  always_comb begin
    front_bank_d   = front_bank_q;
    swap_pending_d = swap_pending_q;
    frame_cnt_d    = frame_cnt_q;
    prev_row_sel_d = row_sel;
    rd_vld_d       = 1'b1;
    if (wrap_s && swap_pending_q) begin
      front_bank_d   = !front_bank_q;
      swap_pending_d = 1'b0;
      frame_cnt_d    = frame_cnt_q + 8'd1;
    end else if (frame_done && !swap_pending_q) begin
      // A wrap in this same cycle does not swap; the swap waits a full scan
      swap_pending_d = 1'b1;
    end else begin
      swap_pending_d = swap_pending_q;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      front_bank_q   <= 1'b0;
      swap_pending_q <= 1'b0;
      frame_cnt_q    <= 8'd0;
      prev_row_sel_q <= {ROW_W{1'b0}};
      rd_vld_q       <= 1'b0;
    end else begin
      front_bank_q   <= front_bank_d;
      swap_pending_q <= swap_pending_d;
      frame_cnt_q    <= frame_cnt_d;
      prev_row_sel_q <= prev_row_sel_d;
      rd_vld_q       <= rd_vld_d;
    end
  end

  fb_ram #(.AW(AW), .DW(12)) u_ram_top (
    .clk     (clk),
    .wr_en   (wr_top_en_s),
    .wr_addr (wr_addr_s),
    .wr_data (wr_rgb),
    .rd_addr (rd_addr_s),
    .rd_data (ram_top_s)
  );

  fb_ram #(.AW(AW), .DW(12)) u_ram_btm (
    .clk     (clk),
    .wr_en   (wr_btm_en_s),
    .wr_addr (wr_addr_s),
    .wr_data (wr_rgb),
    .rd_addr (rd_addr_s),
    .rd_data (ram_btm_s)
  );

  assign wr_ready     = !swap_pending_q;
  assign swap_pending = swap_pending_q;
  assign front_bank   = front_bank_q;
  assign frame_cnt    = frame_cnt_q;
  // RAM read registers have no reset; force zero until the first post-reset read
  assign din_top      = rd_vld_q ? ram_top_s : 12'h000;
  assign din_btm      = rd_vld_q ? ram_btm_s : 12'h000;

endmodule

// File: tb/tb_frame_buf.sv
// Directed scoreboard bench for frame_buf: reads push expected pixels into a
// queue, a negedge monitor pops and compares when read data is due.
module tb_frame_buf;
  import lava_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [5:0]  wr_x;
  logic [4:0]  wr_y;
  logic [11:0] wr_rgb;
  logic        frame_done;
  logic [3:0]  row_sel;
  logic [9:0]  r_addr;
  logic [11:0] din_top;
  logic [11:0] din_btm;
  logic        swap_pending;
  logic        front_bank;
  logic [7:0]  frame_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  logic [23:0] exp_q[$];
  logic        rd_issue = 1'b0;
  logic        rd_pend  = 1'b0;

  always #5 clk = ~clk;

  frame_buf dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .wr_rgb       (wr_rgb),
    .frame_done   (frame_done),
    .row_sel      (row_sel),
    .r_addr       (r_addr),
    .din_top      (din_top),
    .din_btm      (din_btm),
    .swap_pending (swap_pending),
    .front_bank   (front_bank),
    .frame_cnt    (frame_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // A read issued before edge N has its data due after edge N
  always @(posedge clk) rd_pend <= rd_issue;

  // Monitor: compare due read data against the scoreboard
  always @(negedge clk) begin
    if (rd_pend) begin
      chk("rd_expected_present", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [23:0] e;
        e = exp_q.pop_front();
        chk("din_top", 32'(din_top), 32'(e[23:12]));
        chk("din_btm", 32'(din_btm), 32'(e[11:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_read(input logic [9:0] a, input logic [11:0] t, input logic [11:0] b);
    r_addr   = a;
    rd_issue = 1'b1;
    exp_q.push_back({t, b});
    tick();
    rd_issue = 1'b0;
  endtask

  task automatic wr_px(input logic [5:0] x, input logic [4:0] y, input logic [11:0] rgb);
    wr_valid = 1'b1;
    wr_x     = x;
    wr_y     = y;
    wr_rgb   = rgb;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_done();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  task automatic do_wrap();
    row_sel = 4'd15;
    tick();
    row_sel = 4'd0;
    tick();
  endtask

  task automatic chk_state(input string tag, input logic fb, input logic sp, input logic [7:0] fc);
    chk({tag, "_front_bank"},   32'(front_bank),   32'(fb));
    chk({tag, "_swap_pending"}, 32'(swap_pending), 32'(sp));
    chk({tag, "_wr_ready"},     32'(wr_ready),     32'(!sp));
    chk({tag, "_frame_cnt"},    32'(frame_cnt),    32'(fc));
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_x = 6'd0; wr_y = 5'd0; wr_rgb = 12'h000;
    frame_done = 1'b0; row_sel = 4'd0; r_addr = 10'h000;
    repeat (3) tick();

    // Reset values, during and just after release
    chk_state("rst", 1'b0, 1'b0, 8'd0);
    chk("rst_din_top", 32'(din_top), 32'h0);
    chk("rst_din_btm", 32'(din_btm), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rel_din_top", 32'(din_top), 32'h0);
    chk("rel_din_btm", 32'(din_btm), 32'h0);
    tick();

    // Basic frame: fill back bank 1, swap, read back
    wr_px(6'd5, 5'd3,  mk_rgb(4'hF, 4'h0, 4'h0));
    wr_px(6'd5, 5'd19, mk_rgb(4'h0, 4'hA, 4'h0));
    pulse_done();
    chk_state("armed", 1'b0, 1'b1, 8'd0);
    do_wrap();
    chk_state("swap1", 1'b1, 1'b0, 8'd1);
    issue_read(10'h0C5, 12'hF00, 12'h0A0);

    // Writes to the back bank never disturb the displayed bank, even across wraps
    r_addr   = 10'h0C5;
    rd_issue = 1'b1;
    exp_q.push_back({12'hF00, 12'h0A0});
    wr_px(6'd5, 5'd3, 12'h123);
    rd_issue = 1'b0;
    wr_px(6'd5, 5'd19, 12'h456);
    wr_px(6'd0, 5'd0, 12'hABC);
    repeat (3) do_wrap();
    chk_state("nodone", 1'b1, 1'b0, 8'd1);
    issue_read(ra_pack(4'd3, 6'd5), 12'hF00, 12'h0A0);
    pulse_done();
    do_wrap();
    chk_state("swap2", 1'b0, 1'b0, 8'd2);
    issue_read(10'h0C5, 12'h123, 12'h456);
    issue_read(10'h000, 12'hABC, 12'h000 | din_btm_hold());

    // Back-pressure while pending; second frame_done ignored
    pulse_done();
    wr_valid = 1'b1; wr_x = 6'd5; wr_y = 5'd3; wr_rgb = 12'hBAD;
    tick();
    chk("bp_wr_ready", 32'(wr_ready), 32'd0);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    tick();
    wr_valid = 1'b0;
    do_wrap();
    chk_state("swap3", 1'b1, 1'b0, 8'd3);
    issue_read(10'h0C5, 12'hF00, 12'h0A0);
    do_wrap();
    chk_state("ignored", 1'b1, 1'b0, 8'd3);

    // Write coincident with frame_done lands in the pre-swap back bank (0)
    wr_valid = 1'b1; wr_x = 6'd5; wr_y = 5'd3; wr_rgb = 12'h777;
    frame_done = 1'b1;
    tick();
    wr_valid = 1'b0; frame_done = 1'b0;
    do_wrap();
    chk_state("swap4", 1'b0, 1'b0, 8'd4);
    issue_read(10'h0C5, 12'h777, 12'h456);

    // frame_done coincident with a wrap arms but does not swap
    row_sel = 4'd15;
    tick();
    row_sel = 4'd0; frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    chk_state("coinc", 1'b0, 1'b1, 8'd4);
    do_wrap();
    chk_state("swap5", 1'b1, 1'b0, 8'd5);

    // Asynchronous reset while a swap is pending
    pulse_done();
    chk_state("prerst", 1'b1, 1'b1, 8'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("async", 1'b0, 1'b0, 8'd0);
    chk("async_din_top", 32'(din_top), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    repeat (2) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Bottom half of (col 0, row 0) in bank 0 was never written; expect whatever
  // the memory model initialised, which is zero in a two-state simulator.
  function automatic logic [11:0] din_btm_hold();
    return 12'h000;
  endfunction

endmodule
